risc8_ifetch: RTL and testbench

//  Instruction fetch/prefetch stage directly upstream of datapath8 and the control unit.

---
 rtl/risc8_ifetch.sv | 136 +++++++++++++
 tb/tb_risc8_ifetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc8_ifetch.sv
// risc8_ifetch: instruction prefetch stage. Streams bytes from a byte-wide
// synchronous ROM into an address-tagged byte queue and presents variable-length
// (1-4 byte) instructions to the decoder through a valid/ready handshake.
module risc8_ifetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [7:0]  dec_op,
    input  logic [1:0]  dec_isize,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_op,
    output logic [23:0] out_imm,
    output logic [1:0]  out_isize,
    output logic [15:0] out_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [15:0]   tag [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ret_vld;
    logic [15:0]   ret_addr;
    logic [15:0]   fetch_pc;

    logic [CW-1:0] need;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // State register for the run/halt controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt follows the halt input; redirect does not affect the state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (halt)  state_nxt = ST_HALT;
            ST_HALT: if (!halt) state_nxt = ST_RUN;
        endcase
    end

    // Handshake, push and issue decisions; in-flight reads reserve queue slots
    always_comb begin
        need      = CW'(dec_isize) + CW'(1);
        out_valid = (count >= need);
        pop       = out_valid & out_ready;
        push      = ret_vld & ~redirect;
        occupancy = (CW+1)'(count) + (CW+1)'(rom_en) + (CW+1)'(ret_vld) + (CW+1)'(1);
        issue     = (state == ST_RUN) && (redirect || (occupancy <= (CW+1)'(DEPTH)));
    end

    // Head-of-queue instruction view; bytes beyond the instruction read as zero
    always_comb begin
        dec_op    = mem[rd_ptr];
        out_op    = mem[rd_ptr];
        out_pc    = tag[rd_ptr];
        out_isize = dec_isize;
        out_imm   = '0;
        if (dec_isize >= 2'd1) out_imm[7:0]   = mem[rd_ptr + PW'(1)];
        if (dec_isize >= 2'd2) out_imm[15:8]  = mem[rd_ptr + PW'(2)];
        if (dec_isize == 2'd3) out_imm[23:16] = mem[rd_ptr + PW'(3)];
    end

    // Queue, fetch pointer and ROM request registers; redirect flushes and restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
                tag[i] <= RESET_PC;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ret_vld  <= 1'b0;
            ret_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            rom_en   <= 1'b0;
            rom_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                ret_vld <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= rom_rdata;
                    tag[wr_ptr] <= ret_addr;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(need);
                end
                count   <= count + CW'(push) - (pop ? need : CW'(0));
                ret_vld <= rom_en;
            end
            ret_addr <= rom_addr;
            rom_en   <= issue;
            if (issue) begin
                rom_addr <= redirect ? redirect_pc : fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= issue ? (redirect_pc + 16'd1) : redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc8_ifetch.sv
// tb_risc8_ifetch: self-checking bench for the instruction prefetch stage.
// Expected instructions come from walking a ROM image with the opcode size map.
module tb_risc8_ifetch;

    localparam int unsigned DEPTH    = 8;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [7:0]  dec_op;
    logic [1:0]  dec_isize;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_op;
    logic [23:0] out_imm;
    logic [1:0]  out_isize;
    logic [15:0] out_pc;
    logic [49:0] obs;

    logic [7:0]  rom [0:65535];
    int          checks = 0;
    int          errors = 0;

    // Opcode size map of the control unit: a few fixed opcodes, else low two bits
    function automatic logic [1:0] isize_of(input logic [7:0] op);
        case (op)
            8'h10:   return 2'd0;
            8'h20:   return 2'd1;
            8'h30:   return 2'd3;
            default: return op[1:0];
        endcase
    endfunction

    // Reference instruction at pc: {op, imm, pc, isize}
    function automatic logic [49:0] model_instr(input logic [15:0] pc);
        logic [7:0]  op;
        logic [1:0]  n;
        logic [23:0] imm;
        op  = rom[pc];
        n   = isize_of(op);
        imm = '0;
        if (n >= 2'd1) imm[7:0]   = rom[16'(pc + 16'd1)];
        if (n >= 2'd2) imm[15:8]  = rom[16'(pc + 16'd2)];
        if (n == 2'd3) imm[23:16] = rom[16'(pc + 16'd3)];
        return {op, imm, pc, n};
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] pc);
        return 16'(pc + 16'(isize_of(rom[pc])) + 16'd1);
    endfunction

    risc8_ifetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .dec_op     (dec_op),
        .dec_isize  (dec_isize),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_imm    (out_imm),
        .out_isize  (out_isize),
        .out_pc     (out_pc)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (rom_en) rom_rdata <= rom[rom_addr];
    end

    assign dec_isize = isize_of(dec_op);
    assign obs       = {out_op, out_imm, out_pc, out_isize};

    task automatic do_reset();
        rst       = 1'b0;
        redirect  = 1'b0;
        halt      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b expected 0", rom_en); end
        checks++; if (rom_addr !== RESET_PC) begin errors++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, RESET_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== RESET_PC) begin errors++; $display("FAIL reset_out_pc: got %h expected %h", out_pc, RESET_PC); end
        checks++; if (out_op !== 8'h00) begin errors++; $display("FAIL reset_out_op: got %h expected 00", out_op); end
        checks++; if (out_imm !== 24'h0) begin errors++; $display("FAIL reset_out_imm: got %h expected 000000", out_imm); end
    endtask

    // Fixed three-instruction program, consumer always ready
    task automatic test_basic();
        logic [49:0] exp_tab [3];
        int got;
        exp_tab[0] = {8'h10, 24'h000000, 16'h0000, 2'd0};
        exp_tab[1] = {8'h20, 24'h0000AA, 16'h0001, 2'd1};
        exp_tab[2] = {8'h30, 24'h563412, 16'h0003, 2'd3};
        rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'hAA; rom[3] = 8'h30;
        rom[4] = 8'h12; rom[5] = 8'h34; rom[6] = 8'h56;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== RESET_PC) begin
            errors++; $display("FAIL basic_first_fetch: got en=%b addr=%h expected en=1 addr=%h", rom_en, rom_addr, RESET_PC);
        end
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            if (out_valid) begin
                checks++;
                if (obs !== exp_tab[got]) begin
                    errors++; $display("FAIL basic_instr%0d: got %h expected %h", got, obs, exp_tab[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 3) begin errors++; $display("FAIL basic_timeout: got %0d instrs expected 3", got); end
        out_ready = 1'b0;
    endtask

    // Stall fills the queue exactly, outputs hold, then drain loses nothing
    task automatic test_backpressure();
        int issues;
        int got;
        logic [15:0] pc;
        do_reset();
        issues = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rom_en) issues++;
            if (out_valid) begin
                checks++;
                if (obs !== model_instr(RESET_PC)) begin
                    errors++; $display("FAIL bp_frozen cyc%0d: got %h expected %h", cyc, obs, model_instr(RESET_PC));
                end
            end
        end
        checks++; if (issues != DEPTH) begin errors++; $display("FAIL bp_fill_reads: got %0d expected %0d", issues, DEPTH); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL bp_rom_en_full: got %b expected 0", rom_en); end
        pc = RESET_PC;
        got = 0;
        for (int cyc = 0; cyc < 1000 && got < 40; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (obs !== model_instr(pc)) begin
                    errors++; $display("FAIL bp_drain%0d: got %h expected %h", got, obs, model_instr(pc));
                end
                pc = next_pc(pc);
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 40) begin errors++; $display("FAIL bp_timeout: got %0d instrs expected 40", got); end
        out_ready = 1'b0;
    endtask

    // Redirect to a random target, long random-ready stream
    task automatic test_random_stream();
        int got;
        logic [15:0] pc;
        pc = 16'($urandom);
        redirect = 1'b1; redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 3000 && got < 150; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (obs !== model_instr(pc)) begin
                    errors++; $display("FAIL rand_instr%0d: got %h expected %h", got, obs, model_instr(pc));
                end
                pc = next_pc(pc);
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 150) begin errors++; $display("FAIL rand_timeout: got %0d instrs expected 150", got); end
        out_ready = 1'b0;
    endtask

    // Redirect while reads are in flight: stale data dropped, two-cycle latency
    task automatic test_redirect();
        int got;
        logic [15:0] pc;
        rom[16'h1234] = 8'h10;
        do_reset();
        repeat (5) @(negedge clk);
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL redir_inflight: got %b expected 1", rom_en); end
        redirect = 1'b1; redirect_pc = 16'h1234;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h1234) begin
            errors++; $display("FAIL redir_fetch: got en=%b addr=%h expected en=1 addr=1234", rom_en, rom_addr);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_stale: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || obs !== model_instr(16'h1234)) begin
            errors++; $display("FAIL redir_latency: got valid=%b %h expected valid=1 %h", out_valid, obs, model_instr(16'h1234));
        end
        pc = 16'h1234;
        got = 0;
        for (int cyc = 0; cyc < 500 && got < 20; cyc++) begin
            out_ready = ($urandom_range(0, 1) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (obs !== model_instr(pc)) begin
                    errors++; $display("FAIL redir_stream%0d: got %h expected %h", got, obs, model_instr(pc));
                end
                pc = next_pc(pc);
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 20) begin errors++; $display("FAIL redir_timeout: got %0d instrs expected 20", got); end
        out_ready = 1'b0;
    endtask

    // 4-byte instruction straddling the 16-bit address wrap
    task automatic test_wrap();
        logic [15:0] exp_addr [5];
        logic [49:0] exp_i;
        logic        seen;
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000;
        exp_addr[3] = 16'h0001; exp_addr[4] = 16'h0002;
        exp_i = {8'h30, 24'hC3B2A1, 16'hFFFE, 2'd3};
        rom[16'hFFFE] = 8'h30; rom[16'hFFFF] = 8'hA1; rom[16'h0000] = 8'hB2; rom[16'h0001] = 8'hC3;
        out_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rom_en !== 1'b1 || rom_addr !== exp_addr[k]) begin
                errors++; $display("FAIL wrap_addr%0d: got en=%b addr=%h expected en=1 addr=%h", k, rom_en, rom_addr, exp_addr[k]);
            end
            @(negedge clk);
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (obs !== exp_i) begin errors++; $display("FAIL wrap_instr: got %h expected %h", obs, exp_i); end
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL wrap_timeout: got no valid expected valid"); end
    endtask

    // Asynchronous reset mid-cycle, then restart at RESET_PC
    task automatic test_async_reset();
        out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL areset_rom_en: got %b expected 0", rom_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        checks++; if (rom_addr !== RESET_PC) begin errors++; $display("FAIL areset_rom_addr: got %h expected %h", rom_addr, RESET_PC); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== RESET_PC) begin
            errors++; $display("FAIL areset_first_fetch: got en=%b addr=%h expected en=1 addr=%h", rom_en, rom_addr, RESET_PC);
        end
        out_ready = 1'b0;
    endtask

    // Halt with a 2-byte op plus a lone opcode queued
    task automatic test_halt();
        logic        seen;
        logic [49:0] exp_a;
        logic [49:0] exp_b;
        exp_a = {8'h21, 24'h00005A, 16'h0200, 2'd1};
        exp_b = {8'h22, 24'h007C6B, 16'h0202, 2'd2};
        rom[16'h0200] = 8'h21; rom[16'h0201] = 8'h5A; rom[16'h0202] = 8'h22;
        rom[16'h0203] = 8'h6B; rom[16'h0204] = 8'h7C;
        out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        halt = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (obs !== exp_a) begin errors++; $display("FAIL halt_drain: got %h expected %h", obs, exp_a); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL halt_drain_timeout: got no valid expected valid"); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
                errors++; $display("FAIL halt_hold cyc%0d: got valid=%b en=%b expected valid=0 en=0", cyc, out_valid, rom_en);
            end
        end
        halt = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
            @(negedge clk);
            if (rom_en) begin
                seen = 1'b1;
                checks++;
                if (rom_addr !== 16'h0203) begin errors++; $display("FAIL halt_resume_addr: got %h expected 0203", rom_addr); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL halt_resume_timeout: got no fetch expected fetch"); end
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (obs !== exp_b) begin errors++; $display("FAIL halt_resume_instr: got %h expected %h", obs, exp_b); end
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL halt_instr_timeout: got no valid expected valid"); end
        out_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        out_ready   = 1'b0;
        rom_rdata   = 8'h00;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_random_stream();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
